// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: fill/free level codes
// and sizing helpers.
package sync_fifo_pkg;

    localparam logic [3:0] FLAG_EMPTY = 4'h0;
    localparam logic [3:0] FLAG_Q1    = 4'h1;
    localparam logic [3:0] FLAG_Q2    = 4'h2;
    localparam logic [3:0] FLAG_Q3    = 4'h3;
    localparam logic [3:0] FLAG_Q4    = 4'h4;
    localparam logic [3:0] FLAG_FULL  = 4'h8;

    // Occupancy counter width: one more bit than the pointers so DEPTH is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return int'($clog2(depth)) + 32'd1;
    endfunction

    // Quartile code of a level (used for both fill and free space).
    function automatic logic [3:0] level_code(input int unsigned lvl, input int unsigned depth);
        logic [3:0] code;
        if (lvl == 32'd0) begin
            code = FLAG_EMPTY;
        end else if (lvl >= depth) begin
            code = FLAG_FULL;
        end else if (lvl <= depth / 32'd4) begin
            code = FLAG_Q1;
        end else if (lvl <= depth / 32'd2) begin
            code = FLAG_Q2;
        end else if (lvl <= (depth / 32'd4) * 32'd3) begin
            code = FLAG_Q3;
        end else begin
            code = FLAG_Q4;
        end
        return code;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port 1W1R storage with registered read, coded for block-RAM inference.
// A read of the address being written in the same cycle returns the old word.
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; the output register is resettable, the array is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, quartile flags, almost levels and
// sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned DATA_DEPTH       = 1024,
    parameter int unsigned ALMOST_FULL_LVL  = 4,
    parameter int unsigned ALMOST_EMPTY_LVL = 4,
    parameter int unsigned AW               = $clog2(DATA_DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Clk_En,
    input  logic                  Flush,
    input  logic                  PUSH,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  POP,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic [AW:0]           Count,
    output logic [3:0]            PUSH_FLAG,
    output logic [3:0]            POP_FLAG,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int unsigned CW = cnt_width(DATA_DEPTH);
    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C     = CW'(32'd1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] AF_LVL_C  = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0] AE_LVL_C  = CW'(ALMOST_EMPTY_LVL);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(32'd1);

    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic                  act_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic                  ram_we_s;
    logic                  ram_re_s;
    logic [DATA_WIDTH-1:0] ram_q_s;
    logic [CW-1:0]         count_nxt_s;
    logic [CW-1:0]         free_nxt_s;
    logic [3:0]            push_flag_nxt_s;
    logic [3:0]            pop_flag_nxt_s;

`ifdef SYNC_FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] stage_r;
    logic                  use_q_r;
    logic                  ram_has_s;
    logic                  bypass_s;
`endif

    // Acceptance decode from registered occupancy; RAM port controls.
    always_comb begin
        act_s     = Clk_En & ~Flush & ~Rst;
        empty_s   = (Count == ZERO_C);
        full_s    = (Count == DEPTH_C);
        pop_ok_s  = act_s & POP & ~empty_s;
        push_ok_s = act_s & PUSH & (~full_s | pop_ok_s);
`ifdef SYNC_FIFO_FWFT_EN
        // Head word lives outside the RAM; a push that becomes the new head skips the RAM.
        ram_has_s = (Count > ONE_C);
        bypass_s  = push_ok_s & (empty_s | (pop_ok_s & ~ram_has_s));
        ram_we_s  = push_ok_s & ~bypass_s;
        ram_re_s  = pop_ok_s & ram_has_s;
`else
        ram_we_s  = push_ok_s;
        ram_re_s  = pop_ok_s;
`endif
    end

    // Next occupancy and the flag values it implies.
    always_comb begin
        count_nxt_s = Count;
        if (Flush) begin
            count_nxt_s = ZERO_C;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = Count + ONE_C;
                2'b01:   count_nxt_s = Count - ONE_C;
                default: count_nxt_s = Count;
            endcase
        end
        free_nxt_s      = DEPTH_C - count_nxt_s;
        push_flag_nxt_s = level_code(32'(free_nxt_s), DATA_DEPTH);
        pop_flag_nxt_s  = level_code(32'(count_nxt_s), DATA_DEPTH);
    end

    // Pointers, occupancy, flags and sticky error bits.
    always_ff @(posedge Clk) begin
        if (Rst || (Clk_En && Flush)) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            Count        <= ZERO_C;
            PUSH_FLAG    <= FLAG_FULL;
            POP_FLAG     <= FLAG_EMPTY;
            Almost_Full  <= 1'b0;
            Almost_Empty <= 1'b1;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
        end else if (Clk_En) begin
            if (ram_we_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (ram_re_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            Count        <= count_nxt_s;
            PUSH_FLAG    <= push_flag_nxt_s;
            POP_FLAG     <= pop_flag_nxt_s;
            Almost_Full  <= (free_nxt_s <= AF_LVL_C);
            Almost_Empty <= (count_nxt_s <= AE_LVL_C);
            Overflow     <= Overflow | (PUSH & ~push_ok_s);
            Underflow    <= Underflow | (POP & ~pop_ok_s);
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (Clk),
        .rst   (Rst),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (DIN),
        .re    (ram_re_s),
        .raddr (rd_ptr_r),
        .rdata (ram_q_s)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head tracking: either a bypassed word in stage_r or the last RAM read.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stage_r <= {DATA_WIDTH{1'b0}};
            use_q_r <= 1'b0;
        end else if (ram_re_s) begin
            use_q_r <= 1'b1;
        end else if (bypass_s) begin
            stage_r <= DIN;
            use_q_r <= 1'b0;
        end
    end

    assign DOUT = use_q_r ? ram_q_s : stage_r;
`else
    assign DOUT = ram_q_s;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at 16x16 with almost levels of 4.
// Build with SYNC_FIFO_FWFT_EN to exercise the fall-through variant.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        flush;
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic [15:0] dout;
    logic [4:0]  count;
    logic [3:0]  push_flag;
    logic [3:0]  pop_flag;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH       (16),
        .DATA_DEPTH       (16),
        .ALMOST_FULL_LVL  (4),
        .ALMOST_EMPTY_LVL (4)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .Clk_En       (clk_en),
        .Flush        (flush),
        .PUSH         (push),
        .DIN          (din),
        .POP          (pop),
        .DOUT         (dout),
        .Count        (count),
        .PUSH_FLAG    (push_flag),
        .POP_FLAG     (pop_flag),
        .Almost_Full  (almost_full),
        .Almost_Empty (almost_empty),
        .Overflow     (overflow),
        .Underflow    (underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one clock of stimulus; outputs are stable 1 ns after the edge.
    task automatic cycle(input logic p, input logic q, input logic [15:0] d);
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Quartile code for a 16-deep FIFO, thresholds written out by hand.
    function automatic logic [31:0] exp_code(input int lvl);
        if (lvl == 0)       return 32'h0;
        else if (lvl <= 4)  return 32'h1;
        else if (lvl <= 8)  return 32'h2;
        else if (lvl <= 12) return 32'h3;
        else if (lvl <= 15) return 32'h4;
        else                return 32'h8;
    endfunction

    task automatic check_level(input string tag, input int lvl);
        check_eq({tag, "_count"}, 32'(count), 32'(lvl));
        check_eq({tag, "_popflag"}, 32'(pop_flag), exp_code(lvl));
        check_eq({tag, "_pushflag"}, 32'(push_flag), exp_code(16 - lvl));
        check_eq({tag, "_afull"}, 32'(almost_full), (16 - lvl <= 4) ? 32'd1 : 32'd0);
        check_eq({tag, "_aempty"}, 32'(almost_empty), (lvl <= 4) ? 32'd1 : 32'd0);
    endtask

    logic [15:0] model_q[$];
    logic [15:0] exp_dout;
    logic        exp_ovf;
    logic        exp_uf;
    int          mcnt;

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        flush  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        din    = 16'h0000;
        cycle(1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        check_level("reset", 0);
        check_eq("reset_dout", 32'(dout), 32'h0);
        check_eq("reset_ovf", 32'(overflow), 32'd0);
        check_eq("reset_uf", 32'(underflow), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
        cycle(1'b1, 1'b0, 16'hA5A5);
        check_eq("fwft_first", 32'(dout), 32'h0000A5A5);
        check_level("fwft_one", 1);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("fwft_hold", 32'(dout), 32'h0000A5A5);
        cycle(1'b0, 1'b1, 16'h0000);
        check_level("fwft_pop", 0);
        cycle(1'b1, 1'b0, 16'h0B0B);
        cycle(1'b1, 1'b0, 16'h0C0C);
        check_eq("fwft_head_b", 32'(dout), 32'h00000B0B);
        check_level("fwft_two", 2);
        cycle(1'b0, 1'b1, 16'h0000);
        check_eq("fwft_head_c", 32'(dout), 32'h00000C0C);
        check_level("fwft_pop_b", 1);
        cycle(1'b1, 1'b1, 16'h0D0D);
        check_eq("fwft_head_d", 32'(dout), 32'h00000D0D);
        check_level("fwft_pushpop", 1);
        cycle(1'b0, 1'b1, 16'h0000);
        check_level("fwft_drain", 0);
        check_eq("fwft_uf", 32'(underflow), 32'd0);
`else
        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0011 + 16'(i));
        cycle(1'b0, 1'b1, 16'h0000);
        check_eq("t1_dout", 32'(dout), 32'h00000011);
        cycle(1'b1, 1'b0, 16'h0016);
        check_level("t1_five", 5);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 16'h0017);
        rst = 1'b0;
        check_level("t1_rst", 0);
        check_eq("t1_rst_dout", 32'(dout), 32'h0);

        // Fill to full, then one rejected push.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 16'(i));
            check_level($sformatf("t2_push%0d", i), i);
        end
        cycle(1'b1, 1'b0, 16'hDEAD);
        check_level("t2_over", 16);
        check_eq("t2_ovf", 32'(overflow), 32'd1);

        // Drain in order with one-cycle latency, then one rejected pop.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 16'h0000);
            check_eq($sformatf("t3_dout%0d", i), 32'(dout), 32'(i + 1));
            check_level($sformatf("t3_pop%0d", i), 15 - i);
        end
        cycle(1'b0, 1'b1, 16'h0000);
        check_eq("t3_uf", 32'(underflow), 32'd1);
        check_eq("t3_ovf_sticky", 32'(overflow), 32'd1);
        check_eq("t3_dout_hold", 32'(dout), 32'h00000010);
        check_level("t3_under", 0);

        // Clock enable low freezes everything, including flush.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0021 + 16'(i));
        clk_en = 1'b0;
        flush  = 1'b1;
        cycle(1'b1, 1'b1, 16'h0099);
        clk_en = 1'b1;
        flush  = 1'b0;
        check_level("ce_hold", 3);
        check_eq("ce_dout", 32'(dout), 32'h00000010);
        check_eq("ce_ovf", 32'(overflow), 32'd1);

        // Flush clears occupancy and stickies but keeps DOUT.
        flush = 1'b1;
        cycle(1'b1, 1'b1, 16'h0099);
        flush = 1'b0;
        check_level("flush", 0);
        check_eq("flush_ovf", 32'(overflow), 32'd0);
        check_eq("flush_uf", 32'(underflow), 32'd0);
        check_eq("flush_dout", 32'(dout), 32'h00000010);

        // Push and pop on an empty FIFO: only the push is taken.
        cycle(1'b1, 1'b1, 16'h0077);
        check_level("empty_pp", 1);
        check_eq("empty_pp_uf", 32'(underflow), 32'd1);
        check_eq("empty_pp_dout", 32'(dout), 32'h00000010);
        cycle(1'b0, 1'b1, 16'h0000);
        check_eq("empty_pp_data", 32'(dout), 32'h00000077);

        // Full with simultaneous push and pop.
        flush = 1'b1;
        cycle(1'b0, 1'b0, 16'h0000);
        flush = 1'b0;
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 16'(i));
        cycle(1'b1, 1'b1, 16'hBEEF);
        check_level("t4_pp", 16);
        check_eq("t4_dout", 32'(dout), 32'h00000001);
        check_eq("t4_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 17; i++) begin
            cycle(1'b0, 1'b1, 16'h0000);
            check_eq($sformatf("t4_drain%0d", i), 32'(dout), (i == 17) ? 32'h0000BEEF : 32'(i));
        end
        check_level("t4_empty", 0);
        check_eq("t4_uf", 32'(underflow), 32'd0);

        // Random traffic around half full against a queue model.
        flush = 1'b1;
        cycle(1'b0, 1'b0, 16'h0000);
        flush = 1'b0;
        exp_dout = 16'hBEEF;
        exp_ovf  = 1'b0;
        exp_uf   = 1'b0;
        model_q.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 16'h0100 + 16'(i));
            model_q.push_back(16'h0100 + 16'(i));
        end
        for (int i = 0; i < 100; i++) begin
            logic p;
            logic q;
            logic p_ok;
            logic q_ok;
            logic [15:0] d;
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            d = 16'($urandom_range(0, 65535));
            mcnt = model_q.size();
            q_ok = q && (mcnt > 0);
            p_ok = p && ((mcnt < 16) || q_ok);
            if (q_ok) exp_dout = model_q.pop_front();
            if (p_ok) model_q.push_back(d);
            if (p && !p_ok) exp_ovf = 1'b1;
            if (q && !q_ok) exp_uf = 1'b1;
            cycle(p, q, d);
            check_eq($sformatf("t5_dout%0d", i), 32'(dout), 32'(exp_dout));
            check_level($sformatf("t5_lvl%0d", i), model_q.size());
            check_eq($sformatf("t5_ovf%0d", i), 32'(overflow), 32'(exp_ovf));
            check_eq($sformatf("t5_uf%0d", i), 32'(underflow), 32'(exp_uf));
        end
        flush = 1'b1;
        cycle(1'b0, 1'b0, 16'h0000);
        flush = 1'b0;
        check_level("t5_flush", 0);
        check_eq("t5_flush_ovf", 32'(overflow), 32'd0);
        check_eq("t5_flush_uf", 32'(underflow), 32'd0);
        check_eq("t5_flush_dout", 32'(dout), 32'(exp_dout));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
